// File: rtl/alu.sv
//==============================================================================
// Module   : alu
// Purpose  : RV32I integer ALU. Result and flags are combinational; result and
//            zero are also registered.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [3:0]       alu_control,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic [WIDTH-1:0] result_q,
    output logic             zero_q
);

    localparam int       c_SHW   = $clog2(WIDTH);
    localparam int       c_MSB   = WIDTH - 1;

    localparam logic [3:0] c_ADD   = 4'b0000;
    localparam logic [3:0] c_SUB   = 4'b0001;
    localparam logic [3:0] c_SLL   = 4'b0010;
    localparam logic [3:0] c_SLT   = 4'b0011;
    localparam logic [3:0] c_SLTU  = 4'b0100;
    localparam logic [3:0] c_XOR   = 4'b0101;
    localparam logic [3:0] c_SRL   = 4'b0110;
    localparam logic [3:0] c_SRA   = 4'b0111;
    localparam logic [3:0] c_OR    = 4'b1000;
    localparam logic [3:0] c_AND   = 4'b1001;
    localparam logic [3:0] c_PASSB = 4'b1010;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [c_SHW-1:0] w_shamt;
    logic             w_slt;
    logic             w_sltu;
    logic [WIDTH-1:0] w_sra;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_overflow;

    // Widened add/sub so bit WIDTH holds the carry-out / borrow.
    assign w_sum   = {1'b0, operand_a} + {1'b0, operand_b};
    assign w_diff  = {1'b0, operand_a} - {1'b0, operand_b};
    assign w_shamt = operand_b[c_SHW-1:0];
    assign w_slt   = $signed(operand_a) < $signed(operand_b);
    assign w_sltu  = operand_a < operand_b;
    assign w_sra   = $signed(operand_a) >>> w_shamt;

    always_comb begin
        w_result   = '0;
        w_carry    = 1'b0;
        w_overflow = 1'b0;
        case (alu_control)
            c_ADD: begin
                w_result   = w_sum[c_MSB:0];
                w_carry    = w_sum[WIDTH];
                w_overflow = (operand_a[c_MSB] == operand_b[c_MSB]) &&
                             (w_sum[c_MSB] != operand_a[c_MSB]);
            end
            c_SUB: begin
                w_result   = w_diff[c_MSB:0];
                // Carry means "no borrow", i.e. a >= b unsigned.
                w_carry    = ~w_diff[WIDTH];
                w_overflow = (operand_a[c_MSB] != operand_b[c_MSB]) &&
                             (w_diff[c_MSB] != operand_a[c_MSB]);
            end
            c_SLL:   w_result = operand_a << w_shamt;
            c_SLT:   w_result = {{(WIDTH-1){1'b0}}, w_slt};
            c_SLTU:  w_result = {{(WIDTH-1){1'b0}}, w_sltu};
            c_XOR:   w_result = operand_a ^ operand_b;
            c_SRL:   w_result = operand_a >> w_shamt;
            c_SRA:   w_result = w_sra;
            c_OR:    w_result = operand_a | operand_b;
            c_AND:   w_result = operand_a & operand_b;
            c_PASSB: w_result = operand_b;
            default: w_result = '0;
        endcase
    end

    assign result   = w_result;
    assign zero     = ~|w_result;
    assign negative = w_result[c_MSB];
    assign carry    = w_carry;
    assign overflow = w_overflow;

    logic [WIDTH-1:0] r_result_q;
    logic             r_zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result_q <= '0;
            r_zero_q   <= 1'b0;
        end else begin
            r_result_q <= w_result;
            r_zero_q   <= ~|w_result;
        end
    end

    assign result_q = r_result_q;
    assign zero_q   = r_zero_q;

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
//==============================================================================
// Module   : tb_alu
// Purpose  : Directed self-checking bench for alu.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [3:0]  alu_control;
    logic [31:0] result;
    logic        zero;
    logic        negative;
    logic        carry;
    logic        overflow;
    logic [31:0] result_q;
    logic        zero_q;

    int total = 0;
    int bad   = 0;

    alu #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .alu_control (alu_control),
        .result      (result),
        .zero        (zero),
        .negative    (negative),
        .carry       (carry),
        .overflow    (overflow),
        .result_q    (result_q),
        .zero_q      (zero_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        @(negedge clk);
        operand_a   = a;
        operand_b   = b;
        alu_control = op;
        #1;
    endtask

    initial begin
        rst_n       = 1'b1;
        operand_a   = '0;
        operand_b   = '0;
        alu_control = 4'b0000;
        #2 rst_n = 1'b0;
        #1;
        check("rst_result_q", result_q, 32'd0);
        check("rst_zero_q",   {31'd0, zero_q}, 32'd0);

        // ADD basic
        apply(32'd11, 32'd12, 4'b0000);
        check("add_result",   result, 32'd23);
        check("add_zero",     {31'd0, zero}, 32'd0);
        check("add_carry",    {31'd0, carry}, 32'd0);
        check("add_ovf",      {31'd0, overflow}, 32'd0);
        check("rsthold_q",    result_q, 32'd0);

        // SUB
        apply(32'd20, 32'd15, 4'b0001);
        check("sub_result",   result, 32'd5);
        check("sub_carry",    {31'd0, carry}, 32'd1);
        check("sub_ovf",      {31'd0, overflow}, 32'd0);
        apply(32'd5, 32'd5, 4'b0001);
        check("sub_eq_res",   result, 32'd0);
        check("sub_eq_zero",  {31'd0, zero}, 32'd1);
        check("sub_eq_carry", {31'd0, carry}, 32'd1);
        apply(32'd3, 32'd5, 4'b0001);
        check("sub_borrow_r", result, 32'hFFFF_FFFE);
        check("sub_borrow_c", {31'd0, carry}, 32'd0);
        apply(32'h8000_0000, 32'd1, 4'b0001);
        check("sub_ovf_res",  result, 32'h7FFF_FFFF);
        check("sub_ovf_flag", {31'd0, overflow}, 32'd1);

        // Logic ops
        apply(32'h0F0F, 32'hF0F0, 4'b1001);
        check("and_result",   result, 32'h0000_0000);
        check("and_zero",     {31'd0, zero}, 32'd1);
        apply(32'h0F0F, 32'hF0F0, 4'b1000);
        check("or_result",    result, 32'h0000_FFFF);
        apply(32'h0F0F, 32'hF0F0, 4'b0101);
        check("xor_result",   result, 32'h0000_FFFF);
        apply(32'h0F0F, 32'h1234_5678, 4'b1010);
        check("passb_result", result, 32'h1234_5678);

        // Shifts and compares
        apply(32'h8000_0000, 32'h24, 4'b0111);
        check("sra_result",   result, 32'hF800_0000);
        check("sra_neg",      {31'd0, negative}, 32'd1);
        apply(32'h8000_0000, 32'h24, 4'b0110);
        check("srl_result",   result, 32'h0800_0000);
        apply(32'h0000_0001, 32'h21, 4'b0010);
        check("sll_result",   result, 32'h0000_0002);
        apply(32'hDEAD_BEEF, 32'hFFFF_FFE0, 4'b0010);
        check("sll_zero_sh",  result, 32'hDEAD_BEEF);
        apply(32'hFFFF_FFFF, 32'd1, 4'b0011);
        check("slt_result",   result, 32'd1);
        check("slt_zero",     {31'd0, zero}, 32'd0);
        apply(32'hFFFF_FFFF, 32'd1, 4'b0100);
        check("sltu_result",  result, 32'd0);
        check("sltu_zero",    {31'd0, zero}, 32'd1);

        // ADD overflow / carry boundaries
        apply(32'h7FFF_FFFF, 32'd1, 4'b0000);
        check("addovf_res",   result, 32'h8000_0000);
        check("addovf_flag",  {31'd0, overflow}, 32'd1);
        check("addovf_neg",   {31'd0, negative}, 32'd1);
        check("addovf_carry", {31'd0, carry}, 32'd0);
        apply(32'hFFFF_FFFF, 32'd1, 4'b0000);
        check("addc_res",     result, 32'd0);
        check("addc_carry",   {31'd0, carry}, 32'd1);
        check("addc_zero",    {31'd0, zero}, 32'd1);
        check("addc_ovf",     {31'd0, overflow}, 32'd0);

        // Unused opcodes
        apply(32'hFFFF_FFFF, 32'd1, 4'b1111);
        check("op15_result",  result, 32'd0);
        check("op15_zero",    {31'd0, zero}, 32'd1);
        check("op15_carry",   {31'd0, carry}, 32'd0);
        apply(32'h1234_5678, 32'h1234_5678, 4'b1011);
        check("op11_result",  result, 32'd0);

        // Registered path
        apply(32'd5, 32'd5, 4'b0001);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reg_zero_q1",  {31'd0, zero_q}, 32'd1);
        check("reg_res_q0",   result_q, 32'd0);
        apply(32'd11, 32'd12, 4'b0000);
        check("reg_hold_q",   result_q, 32'd0);
        @(posedge clk);
        #1;
        check("reg_result_q", result_q, 32'd23);
        check("reg_zero_q0",  {31'd0, zero_q}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_res_q",  result_q, 32'd0);
        check("async_zero_q", {31'd0, zero_q}, 32'd0);
        check("async_comb",   result, 32'd23);
        @(posedge clk);
        #1;
        check("rst_held_q",   result_q, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
